// File: rtl/ctrl_pkt_pkg.sv
// rtl/ctrl_pkt_pkg.sv - shared types and constants for the control packet transmit path
package ctrl_pkt_pkg;

  typedef struct packed {
    logic [15:0] dest;
    logic [15:0] payload;
  } ctrl_packet_t;

  localparam logic [31:0] CTRL_IDLE      = 32'h0;
  localparam logic [15:0] CTRL_CMD_START = 16'hFFFF;

endpackage

// File: rtl/ctrl_tx_fifo.sv
// rtl/ctrl_tx_fifo.sv - request queue with synchronous push/pop and registered occupancy
module ctrl_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [W-1:0]           wdata,
  input  logic                   pop,
  output logic [W-1:0]           rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok, pop_ok;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Pointers wrap for free because DEPTH is a power of two.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    count_d = count_q + CW'(push_ok) - CW'(pop_ok);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/ctrl_packet_tx.sv
// rtl/ctrl_packet_tx.sv - queues core control requests and emits one framed word in this node's TDM slot
module ctrl_packet_tx
  import ctrl_pkt_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int SLOT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [SLOT_W-1:0]      node_id,
  input  logic [SLOT_W-1:0]      max_node,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [15:0]            req_dest,
  input  logic [15:0]            req_data,
  output logic [31:0]            control_tx_packet,
  output logic                   tx_sent,
  output logic                   req_err,
  output logic [$clog2(DEPTH):0] fifo_count
);

  logic [SLOT_W-1:0] slot_cnt_q, slot_cnt_d;
  logic [31:0]       pkt_q, pkt_d;
  logic              sent_q, sent_d;
  logic              err_q, err_d;
  logic              full, empty, accept, dest_ok, push, pop, tx_slot;
  logic [31:0]       head;
  ctrl_packet_t      word;

  assign req_ready = !full;
  assign accept    = req_valid && req_ready;
  assign dest_ok   = (req_dest != 16'd0) &&
                     (32'(req_dest) <= 32'(max_node)) &&
                     (32'(req_dest) != 32'(node_id));
  assign push      = accept && dest_ok;
  assign tx_slot   = (slot_cnt_q == node_id);
  assign pop       = tx_slot && !empty;

  always_comb begin
    word.dest    = req_dest;
    word.payload = req_data;
  end

  ctrl_tx_fifo #(.DEPTH(DEPTH), .W(32)) u_fifo (
    .clk   (clk),
    .rst_n (rst),
    .push  (push),
    .wdata (word),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  // A shrunk max_node can leave the counter beyond the frame; restart at 1.
  always_comb begin
    slot_cnt_d = slot_cnt_q + SLOT_W'(1);
    if (max_node == '0 || slot_cnt_q >= max_node) slot_cnt_d = SLOT_W'(1);
    pkt_d  = pop ? head : CTRL_IDLE;
    sent_d = pop;
    err_d  = accept && !dest_ok;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_cnt_q <= SLOT_W'(1);
      pkt_q      <= CTRL_IDLE;
      sent_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      slot_cnt_q <= slot_cnt_d;
      pkt_q      <= pkt_d;
      sent_q     <= sent_d;
      err_q      <= err_d;
    end
  end

  assign control_tx_packet = pkt_q;
  assign tx_sent           = sent_q;
  assign req_err           = err_q;

endmodule
